// File: rtl/ctrl_pipe_chain_if.sv
// Purpose: bundles the control-pipeline handshake, stall/flush vectors and status outputs.
// Latency: none, wires only.
// Backpressure: in_ready_o reflects the combinational stall chain of the attached pipeline.
interface ctrl_pipe_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 32
);
  logic                   in_valid_i;
  logic [WIDTH-1:0]       in_ctrl_i;
  logic [DEPTH-1:0]       stall_i;
  logic [DEPTH-1:0]       flush_i;
  logic                   in_ready_o;
  logic [DEPTH*WIDTH-1:0] ctrl_o;
  logic [DEPTH-1:0]       valid_o;
  logic                   retire_o;
  logic [CNT_W-1:0]       retire_cnt;

  // Decoder / hazard-unit side: drives the bundle and the per-stage stall/flush vectors.
  modport master (
    output in_valid_i, in_ctrl_i, stall_i, flush_i,
    input  in_ready_o, ctrl_o, valid_o, retire_o, retire_cnt
  );

  // Pipeline side.
  modport slave (
    input  in_valid_i, in_ctrl_i, stall_i, flush_i,
    output in_ready_o, ctrl_o, valid_o, retire_o, retire_cnt
  );
endinterface

// File: rtl/ctrl_pipe_chain.sv
// Purpose: carries the decoded control bundle from D through DEPTH stages (E .. W) with valid/stall/flush.
// Latency: a bundle accepted at edge t sits in stage k after edge t+k; reaches W after DEPTH edges.
// Backpressure: a stall in stage k freezes k and every stage upstream; in_ready_o drops with any stall.
module ctrl_pipe_chain #(
  parameter int               WIDTH  = 8,
  parameter int               DEPTH  = 3,   // legal range 2..8
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 32
) (
  input  logic clk,
  input  logic reset,
  ctrl_pipe_chain_if.slave bus
);

  logic [DEPTH-1:0]            hold;
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] ctrl_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        retire;

  // A stage holds when it or anything downstream of it stalls; flush never feeds this chain.
  always_comb begin
    hold = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hold[k] = |(bus.stall_i >> k);
    end
  end

  // The W-stage instruction leaves the pipe only if it is valid, not stalled and not squashed.
  always_comb begin
    retire = vld_q[DEPTH-1] & ~bus.stall_i[DEPTH-1] & ~bus.flush_i[DEPTH-1];
  end

  // Stage registers: reset > flush > hold > load/bubble/copy. Invalid stages always carry BUBBLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= BUBBLE;
      end
    end else begin
      // Stage 0 loads straight from D.
      if (bus.flush_i[0]) begin
        vld_q[0]  <= 1'b0;
        ctrl_q[0] <= BUBBLE;
      end else if (!hold[0]) begin
        vld_q[0]  <= bus.in_valid_i;
        ctrl_q[0] <= bus.in_valid_i ? bus.in_ctrl_i : BUBBLE;
      end

      // Later stages copy their predecessor, or take a bubble when the predecessor is frozen.
      for (int k = 1; k < DEPTH; k++) begin
        if (bus.flush_i[k]) begin
          vld_q[k]  <= 1'b0;
          ctrl_q[k] <= BUBBLE;
        end else if (!hold[k]) begin
          if (hold[k-1]) begin
            vld_q[k]  <= 1'b0;
            ctrl_q[k] <= BUBBLE;
          end else begin
            vld_q[k]  <= vld_q[k-1];
            ctrl_q[k] <= ctrl_q[k-1];
          end
        end
      end
    end
  end

  // Retired-instruction counter; wraps naturally, reset takes priority over a retiring edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready_o = ~hold[0];
  assign bus.ctrl_o     = ctrl_q;
  assign bus.valid_o    = vld_q;
  assign bus.retire_o   = retire;
  assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Purpose: checks ctrl_pipe_chain (DEPTH=3) in two builds: BUBBLE=0/CNT_W=32 and BUBBLE=A5/CNT_W=4.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the edges.
// Backpressure: stall/flush vectors come from a directed table, hand sequences and random stimulus.
module tb_ctrl_pipe_chain;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_ctrl;
  logic [2:0] stall;
  logic [2:0] flush;

  int n_vec = 0;
  int n_bad = 0;

  ctrl_pipe_chain_if #(.WIDTH(8), .DEPTH(3), .CNT_W(32)) bus0 ();
  ctrl_pipe_chain_if #(.WIDTH(8), .DEPTH(3), .CNT_W(4))  bus1 ();

  assign bus0.in_valid_i = in_valid;
  assign bus0.in_ctrl_i  = in_ctrl;
  assign bus0.stall_i    = stall;
  assign bus0.flush_i    = flush;
  assign bus1.in_valid_i = in_valid;
  assign bus1.in_ctrl_i  = in_ctrl;
  assign bus1.stall_i    = stall;
  assign bus1.flush_i    = flush;

  ctrl_pipe_chain #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'h00), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  ctrl_pipe_chain #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'hA5), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: pipeline as a row of slots ----------------
  bit          mv [3];
  byte unsigned mc [3];
  int unsigned mcnt;

  // Number of leading stages frozen this cycle (all stages at or below the highest stall).
  function automatic int model_frozen();
    int f = 0;
    for (int k = 0; k < 3; k++) if (stall[k]) f = k + 1;
    return f;
  endfunction

  function automatic bit model_retire();
    return mv[2] && !stall[2] && !flush[2];
  endfunction

  function automatic logic [23:0] model_ctrl(input logic [7:0] b);
    logic [23:0] r;
    for (int k = 0; k < 3; k++) r[k*8 +: 8] = mv[k] ? mc[k] : b;
    return r;
  endfunction

  function automatic logic [2:0] model_valid();
    return {mv[2], mv[1], mv[0]};
  endfunction

  function automatic void model_edge();
    bit           nv [3];
    byte unsigned nc [3];
    int           f;
    bit           ret;
    if (reset) begin
      for (int k = 0; k < 3; k++) mv[k] = 1'b0;
      mcnt = 0;
      return;
    end
    ret = model_retire();
    f   = model_frozen();
    for (int k = 0; k < 3; k++) begin
      nv[k] = mv[k];
      nc[k] = mc[k];
    end
    // Everything above the frozen block slides one slot; the slot right above it gets the new
    // instruction (nothing frozen) or a hole (something frozen).
    for (int k = f; k < 3; k++) begin
      if (k == f) begin
        nv[k] = (f == 0) ? in_valid : 1'b0;
        nc[k] = in_ctrl;
      end else begin
        nv[k] = mv[k-1];
        nc[k] = mc[k-1];
      end
    end
    for (int k = 0; k < 3; k++) if (flush[k]) nv[k] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mv[k] = nv[k];
      mc[k] = nc[k];
    end
    if (ret) mcnt++;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          v;
    logic [7:0]  c;
    logic [2:0]  st;
    logic [2:0]  fl;
    bit          rdy;
    bit          ret;
    logic [2:0]  ev;
    logic [23:0] ec;
    int unsigned ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input logic [7:0] c, input logic [2:0] st, input logic [2:0] fl,
                     input bit rdy, input bit ret, input logic [2:0] ev, input logic [23:0] ec,
                     input int unsigned ecnt);
    vec_t e;
    e.v = v; e.c = c; e.st = st; e.fl = fl; e.rdy = rdy; e.ret = ret;
    e.ev = ev; e.ec = ec; e.ecnt = ecnt;
    tbl.push_back(e);
  endtask

  // One clock: inputs already driven; check combinational outputs, take the edge, check state.
  task automatic step(input string tag);
    #1;
    check({tag, " ready0"}, bus0.in_ready_o, model_frozen() == 0);
    check({tag, " ready1"}, bus1.in_ready_o, model_frozen() == 0);
    check({tag, " retire0"}, bus0.retire_o, model_retire());
    check({tag, " retire1"}, bus1.retire_o, model_retire());
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " valid0"}, bus0.valid_o, model_valid());
    check({tag, " valid1"}, bus1.valid_o, model_valid());
    check({tag, " ctrl0"}, bus0.ctrl_o, model_ctrl(8'h00));
    check({tag, " ctrl1"}, bus1.ctrl_o, model_ctrl(8'hA5));
    check({tag, " cnt0"}, bus0.retire_cnt, mcnt);
    check({tag, " cnt1"}, bus1.retire_cnt, mcnt % 16);
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input logic [2:0] st, input logic [2:0] fl);
    in_valid = v; in_ctrl = c; stall = st; flush = fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 3'b000, 3'b000);
    @(posedge clk);
    model_edge();
    #1;
    // Reset state in both builds.
    check("reset valid0", bus0.valid_o, 3'b000);
    check("reset ctrl0", bus0.ctrl_o, 24'h000000);
    check("reset cnt0", bus0.retire_cnt, 32'd0);
    check("reset ctrl1 bubble", bus1.ctrl_o, 24'hA5A5A5);
    check("reset cnt1", bus1.retire_cnt, 4'd0);
    reset = 1'b0;

    // Directed table: flow, stall bubble, flush-beats-stall, W flush, all-ones flush/stall.
    add(1, 8'h11, 3'b000, 3'b000, 1, 0, 3'b001, 24'h000011, 0);
    add(1, 8'h22, 3'b000, 3'b000, 1, 0, 3'b011, 24'h001122, 0);
    add(1, 8'h33, 3'b000, 3'b000, 1, 0, 3'b111, 24'h112233, 0);
    add(0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b110, 24'h223300, 1);
    add(0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b100, 24'h330000, 2);
    add(0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 24'h000000, 3);
    add(1, 8'h11, 3'b000, 3'b000, 1, 0, 3'b001, 24'h000011, 3);
    add(1, 8'h22, 3'b000, 3'b000, 1, 0, 3'b011, 24'h001122, 3);
    add(1, 8'h33, 3'b000, 3'b000, 1, 0, 3'b111, 24'h112233, 3);
    add(1, 8'h44, 3'b010, 3'b000, 0, 1, 3'b011, 24'h002233, 4);
    add(1, 8'h44, 3'b010, 3'b000, 0, 0, 3'b011, 24'h002233, 4);
    add(1, 8'h55, 3'b001, 3'b001, 0, 0, 3'b100, 24'h220000, 4);
    add(0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 24'h000000, 5);
    add(1, 8'h66, 3'b000, 3'b000, 1, 0, 3'b001, 24'h000066, 5);
    add(1, 8'h77, 3'b000, 3'b000, 1, 0, 3'b011, 24'h006677, 5);
    add(0, 8'h00, 3'b000, 3'b000, 1, 0, 3'b110, 24'h667700, 5);
    add(0, 8'h00, 3'b000, 3'b100, 1, 0, 3'b000, 24'h000000, 5);
    add(1, 8'h88, 3'b000, 3'b000, 1, 0, 3'b001, 24'h000088, 5);
    add(1, 8'h99, 3'b000, 3'b000, 1, 0, 3'b011, 24'h008899, 5);
    add(1, 8'hAA, 3'b000, 3'b111, 1, 0, 3'b000, 24'h000000, 5);
    add(1, 8'hBB, 3'b000, 3'b000, 1, 0, 3'b001, 24'h0000BB, 5);
    add(1, 8'hCC, 3'b111, 3'b000, 0, 0, 3'b001, 24'h0000BB, 5);
    add(1, 8'hCC, 3'b111, 3'b000, 0, 0, 3'b001, 24'h0000BB, 5);
    add(0, 8'h00, 3'b000, 3'b000, 1, 0, 3'b010, 24'h00BB00, 5);

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("row%0d", i);
      drive(tbl[i].v, tbl[i].c, tbl[i].st, tbl[i].fl);
      #1;
      check({t, " tbl ready"}, bus0.in_ready_o, tbl[i].rdy);
      check({t, " tbl retire"}, bus0.retire_o, tbl[i].ret);
      #1;
      check({t, " model ready"}, bus0.in_ready_o, model_frozen() == 0);
      @(posedge clk);
      model_edge();
      #1;
      check({t, " tbl valid"}, bus0.valid_o, tbl[i].ev);
      check({t, " tbl ctrl"}, bus0.ctrl_o, tbl[i].ec);
      check({t, " tbl cnt"}, bus0.retire_cnt, tbl[i].ecnt);
      check({t, " model ctrl1"}, bus1.ctrl_o, model_ctrl(8'hA5));
    end

    // Reset mid-run: fill the pipe, reset while pushing, then time a single push to W.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h30 + 8'(i), 3'b000, 3'b000);
      step("fill");
    end
    reset = 1'b1;
    drive(1'b1, 8'hEE, 3'b000, 3'b000);
    step("midreset");
    check("midreset valid", bus0.valid_o, 3'b000);
    check("midreset ctrl1", bus1.ctrl_o, 24'hA5A5A5);
    check("midreset cnt", bus0.retire_cnt, 32'd0);
    reset = 1'b0;
    drive(1'b1, 8'h5A, 3'b000, 3'b000);
    step("post push");
    check("post e1 W", bus0.valid_o[2], 1'b0);
    drive(1'b0, 8'h00, 3'b000, 3'b000);
    step("post e2");
    check("post e2 W", bus0.valid_o[2], 1'b0);
    step("post e3");
    check("post e3 W valid", bus0.valid_o[2], 1'b1);
    check("post e3 W ctrl", bus0.ctrl_o[23:16], 8'h5A);
    step("post drain");

    // Counter wrap: 17 retirements from zero leave the 4-bit counter at 1.
    reset = 1'b1;
    step("wrap reset");
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i + 1), 3'b000, 3'b000);
      step("wrap push");
    end
    drive(1'b0, 8'h00, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) step("wrap drain");
    check("wrap cnt4", bus1.retire_cnt, 4'd1);
    check("wrap cnt32", bus0.retire_cnt, 32'd17);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_ctrl = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        stall[k] = ($urandom_range(0, 5) == 0);
        flush[k] = ($urandom_range(0, 11) == 0);
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
